// File: rtl/id_stage_pipe.sv
// MIPS decode stage: field split, register file with write-through, EX/MEM/WB forwarding,
// load-use stall and ID/EX pipeline register. Optional stall counter via ID_STALL_CNT_EN.
module id_stage_pipe #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_SEL_W  = 4,
    parameter int PC_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    input  logic [31:0]           if_instr,
    input  logic [PC_W-1:0]       if_pc,
    output logic                  id_ready,
    input  logic                  ex_ready,
    input  logic                  flush,
    output logic [5:0]            op,
    output logic [5:0]            func,
    input  logic                  ctl_w_dst_sel,
    input  logic                  ctl_w_reg_ena,
    input  logic                  ctl_rt_sel,
    input  logic [ALU_SEL_W-1:0]  ctl_alu_sel,
    input  logic [3:0]            ctl_w_mem_ena,
    input  logic                  ctl_wb_sel,
    input  logic [DATA_W-1:0]     ex_fwd_data,
    input  logic                  mem_w_reg_ena,
    input  logic [REG_ADDR_W-1:0] mem_w_addr,
    input  logic [DATA_W-1:0]     mem_w_data,
    input  logic                  wb_w_reg_ena,
    input  logic [REG_ADDR_W-1:0] wb_w_addr,
    input  logic [DATA_W-1:0]     wb_w_data,
    output logic                  id_valid,
    output logic [PC_W-1:0]       id_pc,
    output logic [15:0]           id_imme,
    output logic [25:0]           id_j_imme,
    output logic [REG_ADDR_W-1:0] id_rs,
    output logic [REG_ADDR_W-1:0] id_rt,
    output logic [REG_ADDR_W-1:0] id_dst,
    output logic [DATA_W-1:0]     id_rs_data,
    output logic [DATA_W-1:0]     id_rt_data,
    output logic                  id_mem_r,
    output logic                  id_branch_op,
    output logic                  id_j_op,
    output logic                  id_rt_sel,
    output logic [ALU_SEL_W-1:0]  id_alu_sel,
    output logic [3:0]            id_w_mem_ena,
    output logic                  id_w_reg_ena,
    output logic                  id_wb_sel,
    output logic [31:0]           stall_cnt
);
    localparam int NREG = 1 << REG_ADDR_W;

    logic                  r_valid, r_mem_r, r_branch_op, r_j_op, r_rt_sel, r_w_reg_ena, r_wb_sel;
    logic [PC_W-1:0]       r_pc;
    logic [15:0]           r_imme;
    logic [25:0]           r_j_imme;
    logic [REG_ADDR_W-1:0] r_rs, r_rt, r_dst;
    logic [DATA_W-1:0]     r_rs_data, r_rt_data;
    logic [ALU_SEL_W-1:0]  r_alu_sel;
    logic [3:0]            r_w_mem_ena;
    logic [DATA_W-1:0]     r_regs [NREG];

    logic [REG_ADDR_W-1:0] w_rs, w_rt, w_rd, w_dst;
    logic                  w_mem_r, w_branch_op, w_j_op, w_hazard;
    logic [REG_ADDR_W-1:0] w_src_addr [2];
    logic [DATA_W-1:0]     w_rs_data, w_rt_data;

    assign op          = if_instr[31:26];
    assign func        = if_instr[5:0];
    assign w_rs        = REG_ADDR_W'(if_instr[25:21]);
    assign w_rt        = REG_ADDR_W'(if_instr[20:16]);
    assign w_rd        = REG_ADDR_W'(if_instr[15:11]);
    assign w_dst       = ctl_w_dst_sel ? w_rt : w_rd;
    assign w_mem_r     = (if_instr[31:26] == 6'b100011);
    assign w_branch_op = (if_instr[31:26] == 6'b000100);
    assign w_j_op      = (if_instr[31:26] == 6'b000010);

    assign w_src_addr[0] = w_rs;
    assign w_src_addr[1] = w_rt;

    // A load still in ID/EX has no data yet, so it must not be an EX forwarding source.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic [DATA_W-1:0] w_data;
            always_comb begin
                w_data = r_regs[w_src_addr[gi]];
                if (w_src_addr[gi] == '0)
                    w_data = '0;
                else if (r_valid && r_w_reg_ena && !r_mem_r && r_dst == w_src_addr[gi])
                    w_data = ex_fwd_data;
                else if (mem_w_reg_ena && mem_w_addr == w_src_addr[gi])
                    w_data = mem_w_data;
                else if (wb_w_reg_ena && wb_w_addr == w_src_addr[gi])
                    w_data = wb_w_data;
            end
        end
    endgenerate

    assign w_rs_data = g_src[0].w_data;
    assign w_rt_data = g_src[1].w_data;

    assign w_hazard = if_valid && r_valid && r_mem_r && r_w_reg_ena && (r_dst != '0) &&
                      ((r_dst == w_rs) || (r_dst == w_rt));
    assign id_ready = ex_ready && !w_hazard;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (wb_w_reg_ena && wb_w_addr != '0) begin
            r_regs[wb_w_addr] <= wb_w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || (ex_ready && (flush || w_hazard || !if_valid))) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_imme      <= '0;
            r_j_imme    <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_dst       <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_mem_r     <= 1'b0;
            r_branch_op <= 1'b0;
            r_j_op      <= 1'b0;
            r_rt_sel    <= 1'b0;
            r_alu_sel   <= '0;
            r_w_mem_ena <= '0;
            r_w_reg_ena <= 1'b0;
            r_wb_sel    <= 1'b0;
        end else if (ex_ready) begin
            r_valid     <= 1'b1;
            r_pc        <= if_pc;
            r_imme      <= if_instr[15:0];
            r_j_imme    <= if_instr[25:0];
            r_rs        <= w_rs;
            r_rt        <= w_rt;
            r_dst       <= w_dst;
            r_rs_data   <= w_rs_data;
            r_rt_data   <= w_rt_data;
            r_mem_r     <= w_mem_r;
            r_branch_op <= w_branch_op;
            r_j_op      <= w_j_op;
            r_rt_sel    <= ctl_rt_sel;
            r_alu_sel   <= ctl_alu_sel;
            r_w_mem_ena <= ctl_w_mem_ena;
            r_w_reg_ena <= ctl_w_reg_ena;
            r_wb_sel    <= ctl_wb_sel;
        end
    end

    assign id_valid     = r_valid;
    assign id_pc        = r_pc;
    assign id_imme      = r_imme;
    assign id_j_imme    = r_j_imme;
    assign id_rs        = r_rs;
    assign id_rt        = r_rt;
    assign id_dst       = r_dst;
    assign id_rs_data   = r_rs_data;
    assign id_rt_data   = r_rt_data;
    assign id_mem_r     = r_mem_r;
    assign id_branch_op = r_branch_op;
    assign id_j_op      = r_j_op;
    assign id_rt_sel    = r_rt_sel;
    assign id_alu_sel   = r_alu_sel;
    assign id_w_mem_ena = r_w_mem_ena;
    assign id_w_reg_ena = r_w_reg_ena;
    assign id_wb_sel    = r_wb_sel;

`ifdef ID_STALL_CNT_EN
    logic [31:0] r_stall_cnt;
    always_ff @(posedge clk) begin
        if (!rst)
            r_stall_cnt <= '0;
        else if (ex_ready && !flush && w_hazard)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end
    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed steps then random traffic against a transaction-level model.
module tb_id_stage_pipe;
    logic        clk, rst, if_valid, ex_ready, flush;
    logic [31:0] if_instr, if_pc;
    logic        ctl_w_dst_sel, ctl_w_reg_ena, ctl_rt_sel, ctl_wb_sel;
    logic [3:0]  ctl_alu_sel, ctl_w_mem_ena;
    logic [31:0] ex_fwd_data, mem_w_data, wb_w_data;
    logic        mem_w_reg_ena, wb_w_reg_ena;
    logic [4:0]  mem_w_addr, wb_w_addr;

    logic        id_ready, id_valid, id_mem_r, id_branch_op, id_j_op, id_rt_sel, id_w_reg_ena, id_wb_sel;
    logic [5:0]  op, func;
    logic [31:0] id_pc, id_rs_data, id_rt_data, stall_cnt;
    logic [15:0] id_imme;
    logic [25:0] id_j_imme;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic [3:0]  id_alu_sel, id_w_mem_ena;

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush), .op(op), .func(func),
        .ctl_w_dst_sel(ctl_w_dst_sel), .ctl_w_reg_ena(ctl_w_reg_ena), .ctl_rt_sel(ctl_rt_sel),
        .ctl_alu_sel(ctl_alu_sel), .ctl_w_mem_ena(ctl_w_mem_ena), .ctl_wb_sel(ctl_wb_sel),
        .ex_fwd_data(ex_fwd_data), .mem_w_reg_ena(mem_w_reg_ena), .mem_w_addr(mem_w_addr),
        .mem_w_data(mem_w_data), .wb_w_reg_ena(wb_w_reg_ena), .wb_w_addr(wb_w_addr),
        .wb_w_data(wb_w_data), .id_valid(id_valid), .id_pc(id_pc), .id_imme(id_imme),
        .id_j_imme(id_j_imme), .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_mem_r(id_mem_r),
        .id_branch_op(id_branch_op), .id_j_op(id_j_op), .id_rt_sel(id_rt_sel),
        .id_alu_sel(id_alu_sel), .id_w_mem_ena(id_w_mem_ena), .id_w_reg_ena(id_w_reg_ena),
        .id_wb_sel(id_wb_sel), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the instruction record expected in ID/EX, architectural registers, stall tally.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [15:0] imme;
        logic [25:0] jimme;
        logic [4:0]  rs, rt, dst;
        logic [31:0] rsd, rtd;
        logic        mem_r, br, j, rt_sel;
        logic [3:0]  alu, wmem;
        logic        wreg, wb_sel;
    } idex_t;

    idex_t       m;
    logic [31:0] m_rf [32];
    logic [31:0] m_cnt;
    int          n_pass = 0, n_fail = 0, n_total = 0;
    logic        last_ready;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] o, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {o, rs, rt, imm};
    endfunction

    function automatic logic m_hazard();
        logic [4:0] rs, rt;
        rs = if_instr[25:21];
        rt = if_instr[20:16];
        return if_valid && m.valid && m.mem_r && m.wreg && m.dst != 0 && (m.dst == rs || m.dst == rt);
    endfunction

    // Value of architectural register a as seen by the decoding instruction.
    function automatic logic [31:0] m_operand(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (m.valid && m.wreg && !m.mem_r && m.dst == a) return ex_fwd_data;
        if (mem_w_reg_ena && mem_w_addr == a) return mem_w_data;
        if (wb_w_reg_ena && wb_w_addr == a) return wb_w_data;
        return m_rf[a];
    endfunction

    task automatic model_edge();
        idex_t nxt;
        logic  hz;
        hz = m_hazard();
        if (!rst) begin
            m = '0;
            m_cnt = 0;
            for (int i = 0; i < 32; i++) m_rf[i] = 0;
            return;
        end
        nxt = m;
        if (ex_ready) begin
            if (flush || hz || !if_valid) nxt = '0;
            else begin
                nxt.valid  = 1'b1;
                nxt.pc     = if_pc;
                nxt.imme   = if_instr[15:0];
                nxt.jimme  = if_instr[25:0];
                nxt.rs     = if_instr[25:21];
                nxt.rt     = if_instr[20:16];
                nxt.dst    = ctl_w_dst_sel ? if_instr[20:16] : if_instr[15:11];
                nxt.rsd    = m_operand(if_instr[25:21]);
                nxt.rtd    = m_operand(if_instr[20:16]);
                nxt.mem_r  = if_instr[31:26] == 6'b100011;
                nxt.br     = if_instr[31:26] == 6'b000100;
                nxt.j      = if_instr[31:26] == 6'b000010;
                nxt.rt_sel = ctl_rt_sel;
                nxt.alu    = ctl_alu_sel;
                nxt.wmem   = ctl_w_mem_ena;
                nxt.wreg   = ctl_w_reg_ena;
                nxt.wb_sel = ctl_wb_sel;
            end
            if (!flush && hz) m_cnt = m_cnt + 1;
        end
        if (wb_w_reg_ena && wb_w_addr != 0) m_rf[wb_w_addr] = wb_w_data;
        m = nxt;
    endtask

    task automatic check_regs();
        logic [31:0] exp_cnt;
`ifdef ID_STALL_CNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 0;
`endif
        chk("id_valid", id_valid, m.valid);
        chk("id_pc", id_pc, m.pc);
        chk("id_imme", id_imme, m.imme);
        chk("id_j_imme", id_j_imme, m.jimme);
        chk("id_rs", id_rs, m.rs);
        chk("id_rt", id_rt, m.rt);
        chk("id_dst", id_dst, m.dst);
        chk("id_rs_data", id_rs_data, m.rsd);
        chk("id_rt_data", id_rt_data, m.rtd);
        chk("id_mem_r", id_mem_r, m.mem_r);
        chk("id_branch_op", id_branch_op, m.br);
        chk("id_j_op", id_j_op, m.j);
        chk("id_rt_sel", id_rt_sel, m.rt_sel);
        chk("id_alu_sel", id_alu_sel, m.alu);
        chk("id_w_mem_ena", id_w_mem_ena, m.wmem);
        chk("id_w_reg_ena", id_w_reg_ena, m.wreg);
        chk("id_wb_sel", id_wb_sel, m.wb_sel);
        chk("stall_cnt", stall_cnt, exp_cnt);
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic cycle();
        #1;
        last_ready = id_ready;
        chk("id_ready", id_ready, ex_ready && !m_hazard());
        chk("op", op, if_instr[31:26]);
        chk("func", func, if_instr[5:0]);
        model_edge();
        @(posedge clk);
        #1;
        check_regs();
        @(negedge clk);
    endtask

    logic [31:0] snap_pc, exp_lu_cnt;

    initial begin
        rst = 0; if_valid = 1; ex_ready = 1; flush = 0;
        if_instr = rtype(5, 5, 1, 6'd32); if_pc = 32'h40;
        ctl_w_dst_sel = 0; ctl_w_reg_ena = 0; ctl_rt_sel = 0; ctl_wb_sel = 0;
        ctl_alu_sel = 0; ctl_w_mem_ena = 0;
        ex_fwd_data = 0; mem_w_reg_ena = 0; mem_w_addr = 0; mem_w_data = 0;
        wb_w_reg_ena = 0; wb_w_addr = 0; wb_w_data = 0;
        m = '0; m_cnt = 0;
        for (int i = 0; i < 32; i++) m_rf[i] = 0;
        @(posedge clk);
        @(negedge clk);

        // reset held with a valid instruction offered
        cycle(); cycle();
        chk("rst_valid", id_valid, 0);
        chk("rst_wreg", id_w_reg_ena, 0);

        // first accept after reset; r5 reads zero
        rst = 1; if_instr = rtype(5, 0, 1, 6'd32); if_pc = 32'h100; ctl_w_reg_ena = 1;
        cycle();
        chk("first_accept_valid", id_valid, 1);
        chk("r5_after_reset", id_rs_data, 0);

        // write-through of r3 in the decode cycle, then writes to r0 are ignored
        wb_w_reg_ena = 1; wb_w_addr = 3; wb_w_data = 32'h1234;
        if_instr = rtype(3, 0, 1, 6'd32); if_pc = 32'h104;
        cycle();
        chk("wt_rs_data", id_rs_data, 32'h1234);
        wb_w_addr = 0; wb_w_data = 32'hDEAD; if_instr = rtype(0, 0, 1, 6'd32);
        cycle();
        wb_w_reg_ena = 0; if_instr = rtype(0, 3, 1, 6'd32);
        cycle();
        chk("r0_zero", id_rs_data, 0);
        chk("r3_kept", id_rt_data, 32'h1234);

        // forwarding priority EX > MEM > WB > register file
        if_instr = rtype(1, 1, 2, 6'd32);
        cycle();
        if_instr = rtype(2, 0, 7, 6'd32); ex_fwd_data = 32'hAAAA;
        mem_w_reg_ena = 1; mem_w_addr = 2; mem_w_data = 32'hBBBB;
        wb_w_reg_ena = 1; wb_w_addr = 2; wb_w_data = 32'hCCCC;
        cycle();
        chk("fwd_ex", id_rs_data, 32'hAAAA);
        wb_w_reg_ena = 0;
        cycle();
        chk("fwd_mem", id_rs_data, 32'hBBBB);
        mem_w_reg_ena = 0;
        cycle();
        chk("fwd_rf", id_rs_data, 32'hCCCC);

        // load-use: lw r4,0(r0) then add r5,r4,r4
        if_instr = itype(6'b100011, 0, 4, 16'h0); ctl_w_dst_sel = 1; ctl_wb_sel = 1;
        cycle();
        chk("lw_mem_r", id_mem_r, 1);
        if_instr = rtype(4, 4, 5, 6'd32); ctl_w_dst_sel = 0; ctl_wb_sel = 0;
        cycle();
        chk("lu_ready_low", last_ready, 0);
        chk("lu_bubble", id_valid, 0);
        mem_w_reg_ena = 1; mem_w_addr = 4; mem_w_data = 32'h4444;
        cycle();
        chk("lu_ready_high", last_ready, 1);
        chk("lu_rs_mem", id_rs_data, 32'h4444);
        chk("lu_rt_mem", id_rt_data, 32'h4444);
`ifdef ID_STALL_CNT_EN
        exp_lu_cnt = 1;
`else
        exp_lu_cnt = 0;
`endif
        chk("lu_stall_cnt", stall_cnt, exp_lu_cnt);

        // backpressure freezes ID/EX, then a flush inserts a bubble
        mem_w_reg_ena = 0; snap_pc = id_pc;
        ex_ready = 0; if_instr = rtype(1, 2, 3, 6'd34); if_pc = 32'h200;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_ready", last_ready, 0);
            chk("bp_pc_hold", id_pc, snap_pc);
        end
        ex_ready = 1; flush = 1;
        cycle();
        chk("flush_valid", id_valid, 0);
        chk("flush_wreg", id_w_reg_ena, 0);
        flush = 0;

        // decode of branch, jump and rt destination
        ctl_w_reg_ena = 0; if_instr = itype(6'b000100, 1, 2, 16'h0010);
        cycle();
        chk("dec_branch", id_branch_op, 1);
        if_instr = {6'b000010, 26'h2ABCDEF};
        cycle();
        chk("dec_j", id_j_op, 1);
        chk("dec_j_imme", id_j_imme, 26'h2ABCDEF);
        ctl_w_dst_sel = 1; if_instr = rtype(1, 9, 3, 6'd32);
        cycle();
        chk("dec_dst_rt", id_dst, 9);

        // random traffic on a small register window to provoke hazards and forwarding
        for (int n = 0; n < 400; n++) begin
            logic [5:0] o;
            case ($urandom_range(0, 4))
                0: o = 6'b100011;
                1: o = 6'b000100;
                2: o = 6'b000010;
                3: o = 6'd0;
                default: o = 6'($urandom);
            endcase
            rst           = ($urandom_range(0, 49) != 0);
            ex_ready      = ($urandom_range(0, 4) != 0);
            flush         = ($urandom_range(0, 9) == 0);
            if_valid      = ($urandom_range(0, 3) != 0);
            if_instr      = {o, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                             5'($urandom_range(0, 7)), 11'($urandom)};
            if_pc         = $urandom;
            ctl_w_dst_sel = 1'($urandom);
            ctl_w_reg_ena = 1'($urandom);
            ctl_rt_sel    = 1'($urandom);
            ctl_wb_sel    = 1'($urandom);
            ctl_alu_sel   = 4'($urandom);
            ctl_w_mem_ena = 4'($urandom);
            ex_fwd_data   = $urandom;
            mem_w_reg_ena = 1'($urandom);
            mem_w_addr    = 5'($urandom_range(0, 7));
            mem_w_data    = $urandom;
            wb_w_reg_ena  = 1'($urandom);
            wb_w_addr     = 5'($urandom_range(0, 7));
            wb_w_data     = $urandom;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised MIPS decode stage with a registered ID/EX output stage.
- Splits the instruction into fields and reads an internal register file with WB write-through.
- Forwards results from EX, MEM and WB, detects load-use hazards and stalls IF, and accepts flush bubbles from branch/jump resolution.
- Sits between the IF stage and EX; decode control signals come from the external controller.

Parameters:
- DATA_W, 32: register and data width.
- REG_ADDR_W, 5: register address width; register file has 2^REG_ADDR_W entries.
- ALU_SEL_W, 4: ALU select width.
- PC_W, 32: program counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-low reset.
- if_valid  in  1  IF holds a valid instruction.
- if_instr  in  32  instruction word.
- if_pc  in  PC_W  PC of if_instr.
- id_ready  out  1  ID accepts if_instr this cycle; combinational.
- ex_ready  in  1  EX accepts the ID/EX register this cycle.
- flush  in  1  kill the instruction currently in ID.
- op  out  6  if_instr[31:26], to controller; combinational.
- func  out  6  if_instr[5:0], to controller; combinational.
- ctl_w_dst_sel  in  1  0 selects rd, 1 selects rt as destination.
- ctl_w_reg_ena  in  1  controller signal.
- ctl_rt_sel  in  1  controller signal.
- ctl_alu_sel  in  ALU_SEL_W  controller signal.
- ctl_w_mem_ena  in  4  controller signal.
- ctl_wb_sel  in  1  controller signal.
- ex_fwd_data  in  DATA_W  EX ALU result for the instruction in the ID/EX register.
- mem_w_reg_ena  in  1  MEM-stage writeback enable.
- mem_w_addr  in  REG_ADDR_W  MEM-stage destination register.
- mem_w_data  in  DATA_W  MEM-stage result.
- wb_w_reg_ena  in  1  register file write enable.
- wb_w_addr  in  REG_ADDR_W  register file write address.
- wb_w_data  in  DATA_W  register file write data.
- id_valid  out  1  ID/EX register holds a real instruction.
- id_pc  out  PC_W  registered.
- id_imme  out  16  registered.
- id_j_imme  out  26  registered.
- id_rs  out  REG_ADDR_W  registered.
- id_rt  out  REG_ADDR_W  registered.
- id_dst  out  REG_ADDR_W  registered.
- id_rs_data  out  DATA_W  registered.
- id_rt_data  out  DATA_W  registered.
- id_mem_r  out  1  registered.
- id_branch_op  out  1  registered.
- id_j_op  out  1  registered.
- id_rt_sel  out  1  registered.
- id_alu_sel  out  ALU_SEL_W  registered.
- id_w_mem_ena  out  4  registered.
- id_w_reg_ena  out  1  registered.
- id_wb_sel  out  1  registered.
- stall_cnt  out  32  load-use stall cycle count.

Behaviour:
- Reset: clk, rst as named; rst is synchronous, active-low. With rst=0 at a rising edge, every registered output is cleared to 0, all register file entries are cleared to 0, and stall_cnt is cleared to 0.
- Field decode:
  - rs=[25:21], rt=[20:16], rd=[15:11], imme=[15:0], j_imme=[25:0].
  - rs, rt and rd are truncated or zero-extended to REG_ADDR_W.
  - dst = ctl_w_dst_sel ? rt : rd.
  - mem_r = (op==6'b100011), branch_op = (op==6'b000100), j_op = (op==6'b000010).
- Register file:
  - Two combinational read ports, one synchronous write port.
  - Register 0 always reads 0 and ignores writes.
  - Write-through: reading the wb_w_addr being written in the same cycle (nonzero addr, wb_w_reg_ena=1) returns wb_w_data.
- Forwarding, per source operand, with address a:
  - a==0 gives 0.
  - Else priority EX > MEM > WB/regfile.
  - EX match: id_valid & id_w_reg_ena & ~id_mem_r & id_dst==a gives ex_fwd_data.
  - MEM match: mem_w_reg_ena & mem_w_addr==a gives mem_w_data.
- Load-use hazard:
  - hazard = if_valid & id_valid & id_mem_r & id_w_reg_ena & id_dst!=0 & (id_dst==rs | id_dst==rt).
  - id_ready = ex_ready & ~hazard.
- ID/EX register update, evaluated at each rising edge in this priority order:
  1. rst=0: clear everything.
  2. ex_ready=0: hold every output unchanged. flush is ignored; the flush source holds flush asserted until ex_ready=1.
  3. flush=1: insert a bubble.
  4. hazard=1: insert a bubble. IF must hold if_instr.
  5. if_valid=0: insert a bubble.
  6. Otherwise load decoded fields, forwarded data and controller signals, and set id_valid=1.
- Bubble contents: id_valid=0, id_w_reg_ena=0, id_w_mem_ena=0, id_mem_r=0, id_branch_op=0, id_j_op=0. All other fields are don't-care; the implementation zeroes them.
- Latency: one cycle from accept (if_valid & id_ready) to id_valid=1.
- A load-use stall lasts exactly 1 cycle. After the stall cycle the load has left ID/EX and its data is forwarded from MEM.

Optional Feature:
- Macro: ID_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 on every rising edge where rst=1, ex_ready=1, flush=0 and hazard=1. It wraps from 0xFFFFFFFF to 0.
- Undefined: stall_cnt is tied to 0 and no counter logic is generated.

Test Plan:
- Reset: rst=0 for 2 cycles with if_valid=1 -> all id_* outputs are 0 and reading r5 returns 0; after rst=1, id_valid rises one cycle after the first accept.
- WB write-through: wb writes r3=0x1234 while ID decodes add r1,r3,r0 -> id_rs_data=0x1234 in the same accept; writes to r0 -> r0 still reads 0.
- Forward priority: r2 is the EX destination (fwd 0xAAAA), MEM (0xBBBB) and WB (0xCCCC) in the same cycle -> id_rs_data=0xAAAA; with the EX match removed -> 0xBBBB.
- Load-use: lw r4,0(r0) followed by add r5,r4,r4 -> id_ready=0 for exactly 1 cycle and a bubble is issued; the add then issues with r4 taken from mem_w_data; stall_cnt=1 with ID_STALL_CNT_EN defined.
- Backpressure and flush: ex_ready=0 for 3 cycles -> outputs frozen and id_ready=0; flush=1 with ex_ready=1 -> next cycle id_valid=0 and id_w_reg_ena=0.
- Decode: op 000100 -> id_branch_op=1; op 000010 -> id_j_op=1 and id_j_imme=if_instr[25:0]; ctl_w_dst_sel=1 -> id_dst=rt.
